// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM states, default depth
// and the word-index width helper.
package dmem_pkg;

    typedef enum logic [1:0] {
        CLEAR    = 2'd0,
        IDLE     = 2'd1,
        HOST_ACC = 2'd2,
        HOST_ACK = 2'd3
    } state_t;

    localparam int DEFAULT_DEPTH = 1024;

    function automatic int idx_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-wide storage: one synchronous write port, an asynchronous CPU read
// port and an asynchronous host read port.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int IW    = idx_width(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [IW-1:0] wr_idx,
    input  logic [31:0]   wr_data,
    input  logic [IW-1:0] cpu_idx,
    output logic [31:0]   cpu_rdata,
    input  logic [IW-1:0] host_idx,
    output logic [31:0]   host_rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign cpu_rdata  = mem[cpu_idx];
    assign host_rdata = mem[host_idx];

endmodule

// File: rtl/dmem_responder.sv
// Zero-latency data memory for a single-cycle core with a post-reset clear
// sweep and a low-priority host loader port. DMEM_STATS_EN adds access counters.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        ready_o,
    output logic        err_o,
    input  logic        host_req_i,
    input  logic        host_we_i,
    input  logic [31:0] host_addr_i,
    input  logic [31:0] host_wdata_i,
    output logic [31:0] host_rdata_o,
    output logic        host_ack_o,
    output logic [31:0] rd_cnt_o,
    output logic [31:0] wr_cnt_o
);

    localparam int          IW        = idx_width(DEPTH);
    localparam logic [31:0] MEM_BYTES = 32'(DEPTH) << 2;

    state_t        state;
    logic [IW-1:0] clr_idx;
    logic          h_we;
    logic          h_oor;
    logic [IW-1:0] h_idx;
    logic [31:0]   h_wdata;

    logic [IW-1:0] cpu_idx;
    logic          cpu_mis;
    logic          cpu_oor;
    logic          busy_clear;
    logic          cpu_st_ok;
    logic          host_wr_go;
    logic          wr_en;
    logic [IW-1:0] wr_idx;
    logic [31:0]   wr_data;
    logic [31:0]   cpu_rdata;
    logic [31:0]   host_rdata;

    assign cpu_idx    = addr_i[IW+1:2];
    assign cpu_mis    = (addr_i[1:0] != 2'b00);
    assign cpu_oor    = (addr_i >= MEM_BYTES);
    assign busy_clear = (state == CLEAR);
    assign cpu_st_ok  = ce_i & we_i & ~cpu_mis & ~cpu_oor & ~busy_clear;
    assign host_wr_go = (state == HOST_ACC) & ~ce_i & h_we & ~h_oor;

    // Single write port shared by the sweep, CPU stores and deferred host writes
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = cpu_idx;
        wr_data = data_i;
        if (busy_clear) begin
            wr_en   = 1'b1;
            wr_idx  = clr_idx;
            wr_data = '0;
        end else if (cpu_st_ok) begin
            wr_en = 1'b1;
        end else if (host_wr_go) begin
            wr_en   = 1'b1;
            wr_idx  = h_idx;
            wr_data = h_wdata;
        end
    end

    dmem_array #(
        .DEPTH (DEPTH),
        .IW    (IW)
    ) u_array (
        .clk        (clk),
        .wr_en      (wr_en),
        .wr_idx     (wr_idx),
        .wr_data    (wr_data),
        .cpu_idx    (cpu_idx),
        .cpu_rdata  (cpu_rdata),
        .host_idx   (h_idx),
        .host_rdata (host_rdata)
    );

    // Misaligned loads still return the aligned word; only out-of-range reads are masked
    assign data_o = (ce_i & ~we_i & ~cpu_oor & ~busy_clear) ? cpu_rdata : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= CLEAR;
            clr_idx      <= '0;
            ready_o      <= 1'b0;
            err_o        <= 1'b0;
            host_ack_o   <= 1'b0;
            host_rdata_o <= '0;
            h_we         <= 1'b0;
            h_oor        <= 1'b0;
            h_idx        <= '0;
            h_wdata      <= '0;
        end else begin
            if (ce_i && (busy_clear || cpu_mis || cpu_oor)) begin
                err_o <= 1'b1;
            end
            case (state)
                CLEAR: begin
                    clr_idx <= clr_idx + 1'b1;
                    if (clr_idx == IW'(DEPTH - 1)) begin
                        state   <= IDLE;
                        ready_o <= 1'b1;
                    end
                end
                IDLE: begin
                    if (host_req_i && !ce_i) begin
                        h_we    <= host_we_i;
                        h_idx   <= host_addr_i[IW+1:2];
                        h_oor   <= (host_addr_i >= MEM_BYTES);
                        h_wdata <= host_wdata_i;
                        state   <= HOST_ACC;
                    end
                end
                HOST_ACC: begin
                    if (!ce_i) begin
                        host_rdata_o <= (h_we || h_oor) ? '0 : host_rdata;
                        host_ack_o   <= 1'b1;
                        state        <= HOST_ACK;
                    end
                end
                HOST_ACK: begin
                    host_ack_o <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= CLEAR;
            endcase
        end
    end

`ifdef DMEM_STATS_EN
    logic cpu_ld_ok;
    assign cpu_ld_ok = ce_i & ~we_i & ~cpu_mis & ~cpu_oor & ~busy_clear;

    // Saturating counters of legal CPU accesses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_cnt_o <= '0;
            wr_cnt_o <= '0;
        end else begin
            if (cpu_ld_ok && (rd_cnt_o != 32'hFFFF_FFFF)) begin
                rd_cnt_o <= rd_cnt_o + 32'd1;
            end
            if (cpu_st_ok && (wr_cnt_o != 32'hFFFF_FFFF)) begin
                wr_cnt_o <= wr_cnt_o + 32'd1;
            end
        end
    end
`else
    assign rd_cnt_o = '0;
    assign wr_cnt_o = '0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed plus randomized bench for dmem_responder against a word-array
// reference model.
module tb_dmem_responder;

    localparam int DEPTH = 1024;
    localparam logic [31:0] MEM_BYTES = 32'(DEPTH) * 4;

    logic        clk;
    logic        rst;
    logic        ce_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        ready_o;
    logic        err_o;
    logic        host_req_i;
    logic        host_we_i;
    logic [31:0] host_addr_i;
    logic [31:0] host_wdata_i;
    logic [31:0] host_rdata_o;
    logic        host_ack_o;
    logic [31:0] rd_cnt_o;
    logic [31:0] wr_cnt_o;

    int errors;
    int checks;

    logic [31:0] model_mem [DEPTH];
    bit          exp_err;
    int          exp_rd;
    int          exp_wr;
    bit          stats_on;

    dmem_responder #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .ce_i         (ce_i),
        .we_i         (we_i),
        .addr_i       (addr_i),
        .data_i       (data_i),
        .data_o       (data_o),
        .ready_o      (ready_o),
        .err_o        (err_o),
        .host_req_i   (host_req_i),
        .host_we_i    (host_we_i),
        .host_addr_i  (host_addr_i),
        .host_wdata_i (host_wdata_i),
        .host_rdata_o (host_rdata_o),
        .host_ack_o   (host_ack_o),
        .rd_cnt_o     (rd_cnt_o),
        .wr_cnt_o     (wr_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic ce, input logic we,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        ce_i   = ce;
        we_i   = we;
        addr_i = addr;
        data_i = wdata;
    endtask

    task automatic clearModel();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        exp_err = 1'b0;
        exp_rd  = 0;
        exp_wr  = 0;
    endtask

    function automatic logic [31:0] modelLoad(input logic [31:0] addr);
        if (addr >= MEM_BYTES) return '0;
        return model_mem[addr / 4];
    endfunction

    // One CPU cycle in the ready state; data_o is checked before the edge
    task automatic cpuCycle(input string tag, input logic ce, input logic we,
                            input logic [31:0] addr, input logic [31:0] wdata);
        bit legal;
        applyStimulus(ce, we, addr, wdata);
        #1;
        checkOutput({tag, "_data"}, data_o, (ce && !we) ? modelLoad(addr) : 32'h0);
        legal = (addr % 4 == 0) && (addr < MEM_BYTES);
        if (ce) begin
            if (!legal) exp_err = 1'b1;
            else if (we) begin
                model_mem[addr / 4] = wdata;
                exp_wr++;
            end else exp_rd++;
        end
        @(posedge clk);
        #1;
        checkOutput({tag, "_err"}, {31'd0, err_o}, {31'd0, exp_err});
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic checkCounters(input string tag);
        checkOutput({tag, "_rd"}, rd_cnt_o, stats_on ? 32'(exp_rd) : 32'h0);
        checkOutput({tag, "_wr"}, wr_cnt_o, stats_on ? 32'(exp_wr) : 32'h0);
    endtask

    task automatic waitReady(output int n);
        n = 0;
        while (n < 1200) begin
            @(posedge clk);
            #1;
            n++;
            if (ready_o) break;
        end
    endtask

    // Host transaction, assumes CPU idle; returns cycles from request to ack
    task automatic hostAccess(input bit we, input logic [31:0] addr,
                              input logic [31:0] wdata, output logic [31:0] rd,
                              output int lat);
        host_req_i   = 1'b1;
        host_we_i    = we;
        host_addr_i  = addr;
        host_wdata_i = wdata;
        lat = 0;
        while (lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (host_ack_o) break;
        end
        rd = host_rdata_o;
        host_req_i = 1'b0;
        if (we && addr < MEM_BYTES) model_mem[addr / 4] = wdata;
        @(posedge clk);
        #1;
        checkOutput("host_ack_pulse", {31'd0, host_ack_o}, 32'h0);
    endtask

    initial begin
        int          n;
        int          lat;
        logic [31:0] rd;
        logic [31:0] a;
        logic [31:0] d;
        bit          w;

        errors = 0;
        checks = 0;
`ifdef DMEM_STATS_EN
        stats_on = 1'b1;
`else
        stats_on = 1'b0;
`endif
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        host_req_i   = 1'b0;
        host_we_i    = 1'b0;
        host_addr_i  = '0;
        host_wdata_i = '0;
        clearModel();

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_ready", {31'd0, ready_o}, 32'h0);
        checkOutput("rst_err", {31'd0, err_o}, 32'h0);
        checkOutput("rst_ack", {31'd0, host_ack_o}, 32'h0);
        checkOutput("rst_hrdata", host_rdata_o, 32'h0);
        checkCounters("rst_cnt");

        rst = 1'b1;
        waitReady(n);
        checkOutput("sweep_cycles", 32'(n), 32'd1024);

        cpuCycle("load_0x10", 1'b1, 1'b0, 32'h10, 32'h0);
        cpuCycle("store_0x20", 1'b1, 1'b1, 32'h20, 32'hDEADBEEF);
        cpuCycle("load_0x20", 1'b1, 1'b0, 32'h20, 32'h0);

        cpuCycle("ld_a", 1'b1, 1'b0, 32'h0, 32'h0);
        cpuCycle("st_a", 1'b1, 1'b1, 32'h24, 32'hA5A5_0001);
        cpuCycle("ld_b", 1'b1, 1'b0, 32'h24, 32'h0);
        cpuCycle("st_b", 1'b1, 1'b1, 32'hFFC, 32'h0BAD_F00D);
        cpuCycle("ld_c", 1'b1, 1'b0, 32'hFFC, 32'h0);
        checkCounters("cnt_5_3");

        // Host write held off by three CPU cycles
        host_req_i   = 1'b1;
        host_we_i    = 1'b1;
        host_addr_i  = 32'h40;
        host_wdata_i = 32'h12345678;
        for (int i = 0; i < 3; i++) begin
            cpuCycle("cpu_hold", 1'b1, 1'b0, 32'h44, 32'h0);
            checkOutput("host_wait_ack", {31'd0, host_ack_o}, 32'h0);
        end
        hostAccess(1'b1, 32'h40, 32'h12345678, rd, lat);
        checkOutput("host_wr_lat", 32'(lat), 32'd2);
        checkOutput("host_wr_rdata", rd, 32'h0);
        hostAccess(1'b0, 32'h40, 32'h0, rd, lat);
        checkOutput("host_rd_data", rd, 32'h12345678);
        cpuCycle("cpu_ld_0x40", 1'b1, 1'b0, 32'h40, 32'h0);

        hostAccess(1'b1, 32'h2000, 32'hFFFF_FFFF, rd, lat);
        hostAccess(1'b0, 32'h2000, 32'h0, rd, lat);
        checkOutput("host_oor_rdata", rd, 32'h0);
        checkOutput("host_oor_err", {31'd0, err_o}, 32'h0);

        for (int i = 0; i < 40; i++) begin
            a = 32'($urandom_range(0, 63)) * 4;
            d = $urandom;
            w = 1'($urandom_range(0, 1));
            cpuCycle("rand", 1'b1, w, a, d);
        end
        checkCounters("rand_cnt");

        cpuCycle("store_mis", 1'b1, 1'b1, 32'h22, 32'h1111_2222);
        cpuCycle("store_oor", 1'b1, 1'b1, 32'h1000, 32'h3333_4444);
        cpuCycle("load_mis", 1'b1, 1'b0, 32'h22, 32'h0);
        cpuCycle("load_oor", 1'b1, 1'b0, 32'h1000, 32'h0);
        cpuCycle("check_0x20", 1'b1, 1'b0, 32'h20, 32'h0);
        cpuCycle("check_0x0", 1'b1, 1'b0, 32'h0, 32'h0);
        checkCounters("err_cnt");

        // Reset mid-sweep, with a CPU access during the sweep
        rst = 1'b0;
        #1;
        rst = 1'b1;
        clearModel();
        for (int i = 1; i <= 500; i++) begin
            if (i == 300) begin
                applyStimulus(1'b1, 1'b0, 32'h20, 32'h0);
                #1;
                checkOutput("clear_load", data_o, 32'h0);
            end
            @(posedge clk);
            #1;
            if (i == 300) begin
                applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
                checkOutput("clear_ce_err", {31'd0, err_o}, 32'h1);
            end
        end
        checkOutput("mid_ready", {31'd0, ready_o}, 32'h0);
        rst = 1'b0;
        #1;
        checkOutput("mid_rst_ready", {31'd0, ready_o}, 32'h0);
        checkOutput("mid_rst_err", {31'd0, err_o}, 32'h0);
        checkCounters("mid_rst_cnt");
        rst = 1'b1;
        waitReady(n);
        checkOutput("resweep_cycles", 32'(n), 32'd1024);
        cpuCycle("resweep_0x20", 1'b1, 1'b0, 32'h20, 32'h0);
        cpuCycle("resweep_0x40", 1'b1, 1'b0, 32'h40, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, data memory size in 32-bit words (power of two, 16..65536).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port ce_i  input  1  CPU data chip select.
REQ-005 SHALL have port we_i  input  1  CPU write enable (1 = store, 0 = load).
REQ-006 SHALL have port addr_i  input  32  CPU byte address.
REQ-007 SHALL have port data_i  input  32  CPU store data.
REQ-008 SHALL have port data_o  output  32  load data to CPU.
REQ-009 SHALL have port ready_o  output  1  high once the post-reset clear sweep has completed.
REQ-010 SHALL have port err_o  output  1  sticky access-error flag.
REQ-011 SHALL have ports host_req_i / host_we_i (in, 1), host_addr_i (in, 32), host_wdata_i (in, 32), host_rdata_o (out, 32) and host_ack_o (out, 1), forming the program-loader/debug port.
REQ-012 SHALL have ports rd_cnt_o and wr_cnt_o  output  32  CPU access counters.

Function
REQ-013 SHALL derive the word index from addr_i[log2(DEPTH)+1:2].
REQ-014 SHALL drive data_o combinationally with mem[index] in the same cycle when ce_i=1, we_i=0 and the access is legal, and with 0 otherwise (zero-latency for the single-cycle core).
REQ-015 SHALL perform a CPU store at the clk edge while ce_i=1, we_i=1 and the access is legal.
REQ-016 SHALL treat addr_i[1:0]!=0 as misaligned: set err_o, suppress the write, and read the aligned word.
REQ-017 SHALL treat addr_i >= 4*DEPTH as out-of-range: set err_o, suppress the write, and return 0.
REQ-018 SHALL implement an FSM with states CLEAR, IDLE, HOST_ACC and HOST_ACK.
REQ-019 SHALL, in CLEAR, write 0 to one word per cycle from index 0 to DEPTH-1, then go to IDLE and raise ready_o; clearing takes exactly DEPTH cycles.
REQ-020 SHALL, during CLEAR, return 0 for CPU loads, drop CPU stores, set err_o for any ce_i=1, and ignore host_req_i.
REQ-021 SHALL, in IDLE with host_req_i=1 and ce_i=0, latch the host request and go to HOST_ACC; the CPU has priority, so with ce_i=1 the host waits in IDLE.
REQ-022 SHALL, in HOST_ACC, perform the host read or write, then go to HOST_ACK; a CPU access in the same cycle is served and the host access is deferred one cycle.
REQ-023 SHALL, in HOST_ACK, pulse host_ack_o for one cycle with host_rdata_o valid (0 for writes), then return to IDLE.
REQ-024 SHALL give an out-of-range host address no write and host_rdata_o=0, without setting err_o.
REQ-025 SHALL treat host_req_i still high in IDLE after an ack as a new request.
REQ-026 SHALL clear err_o only via reset.

Reset
REQ-027 SHALL, on rst=0, force state=CLEAR, clear index=0, ready_o=0, err_o=0, host_ack_o=0, host_rdata_o=0, rd_cnt_o=0 and wr_cnt_o=0 immediately.
REQ-028 SHALL, when reset is asserted mid-sweep or mid-host-access, abort the operation and restart the sweep from index 0 after release.

Configuration
REQ-029 SHALL, with DMEM_STATS_EN defined, increment rd_cnt_o per legal CPU load cycle and wr_cnt_o per legal CPU store cycle, both saturating at 32'hFFFF_FFFF.
REQ-030 SHALL, without DMEM_STATS_EN, tie rd_cnt_o and wr_cnt_o to 0 and instantiate no counter logic.

Structure
REQ-031 SHALL place the FSM state enum, the default DEPTH and the word-index width function in shared package dmem_pkg.
REQ-032 SHALL isolate storage in sub-module dmem_array (one write port, one async read port, one host read port).

Verification
REQ-033 SHALL cover: release reset, count cycles -> ready_o rises exactly 1024 cycles later; a CPU load at 0x10 then returns 0.
REQ-034 SHALL cover: CPU store 0xDEADBEEF to 0x20, load 0x20 in the next cycle -> data_o=0xDEADBEEF in the same cycle, err_o=0.
REQ-035 SHALL cover: store to 0x22, then store to 0x1000 -> err_o=1, and words 0x20 and 0 are unchanged.
REQ-036 SHALL cover: host write 0x12345678 to 0x40 while ce_i=1 for 3 cycles -> ack after the CPU releases; a subsequent host read returns 0x12345678.
REQ-037 SHALL cover: reset asserted at sweep index 500 -> ready_o=0 and a full 1024-cycle sweep follows release.
REQ-038 SHALL cover, with DMEM_STATS_EN: 5 loads and 3 stores -> rd_cnt_o=5, wr_cnt_o=3; without the macro, both read 0.
